// File: rtl/naneye_out_pkg.sv
// naneye_out_pkg: shared state encoding and FIFO entry layout for the NanEye output formatter
package naneye_out_pkg;

    typedef enum logic [1:0] {WAIT, LINE, BLANK} state_t;

    localparam int PIX_POS = 0;

    function automatic int entry_w(input int dw);
        return dw + 3;
    endfunction

    function automatic int pv_pos(input int dw);
        return dw;
    endfunction

    function automatic int eol_pos(input int dw);
        return dw + 1;
    endfunction

    function automatic int sof_pos(input int dw);
        return dw + 2;
    endfunction

endpackage

// File: rtl/naneye_out_fifo.sv
// naneye_out_fifo: synchronous FIFO with occupancy count that accepts a write into a full FIFO when a pop happens in the same cycle
module naneye_out_fifo #(
    parameter int W     = 13,
    parameter int DEPTH = 16
) (
    input  logic                       SCLOCK,
    input  logic                       RESET,
    input  logic                       wr_en,
    input  logic [W-1:0]               wr_data,
    input  logic                       rd_en,
    output logic [W-1:0]               rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       wr_ok
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          rd_ok;

    assign empty   = count == '0;
    assign rd_ok   = rd_en && !empty;
    assign wr_ok   = wr_en && (count != (AW+1)'(DEPTH) || rd_ok);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge SCLOCK) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge SCLOCK) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ok ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= rd_ok ? rd_ptr + 1'b1 : rd_ptr;
            count  <= count + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
        end
    end

endmodule

// File: rtl/naneye_out_fmt.sv
// naneye_out_fmt: re-paces bursty NanEye pixel strobes into an evenly clocked PAR_OUT/H_SYNC/V_SYNC/PCLK video stream
module naneye_out_fmt
    import naneye_out_pkg::*;
#(
    parameter int D_WIDTH    = 10,
    parameter int PCLK_DIV   = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int PREFILL    = 8,
    parameter int HB_MIN     = 4,
    parameter int VS_WIDTH   = 2
) (
    input  logic               SCLOCK,
    input  logic               RESET,
    input  logic [D_WIDTH-1:0] PAR_IN,
    input  logic               PAR_EN,
    input  logic               LINE_END,
    input  logic               FRAME_SYNC,
    output logic [D_WIDTH-1:0] PAR_OUT,
    output logic               H_SYNC,
    output logic               V_SYNC,
    output logic               PCLK,
    output logic               OVERFLOW,
    output logic               UNDERRUN
);
    localparam int EW   = entry_w(D_WIDTH);
    localparam int CW   = $clog2(FIFO_DEPTH) + 1;
    localparam int DIVW = $clog2(PCLK_DIV);
    localparam int HBW  = $clog2(HB_MIN + 1);
    localparam int VSW  = $clog2(VS_WIDTH + 1);

    state_t             state, state_n;
    logic [DIVW-1:0]    div_cnt, div_n;
    logic [EW-1:0]      head;
    logic [CW-1:0]      count, eol_cnt, eol_n;
    logic [HBW-1:0]     hb_cnt, hb_n;
    logic [VSW-1:0]     vs_cnt, vs_n;
    logic [D_WIDTH-1:0] par_n, hd_pix;
    logic               tick, empty, wr_en, wr_ok, pop, h_n, und_n;
    logic               hd_sof, hd_eol, hd_pv;

    assign tick   = div_cnt == DIVW'(PCLK_DIV - 1);
    assign div_n  = tick ? '0 : div_cnt + 1'b1;
    assign wr_en  = PAR_EN | LINE_END | FRAME_SYNC;
    assign hd_sof = head[sof_pos(D_WIDTH)];
    assign hd_eol = head[eol_pos(D_WIDTH)];
    assign hd_pv  = head[pv_pos(D_WIDTH)];
    assign hd_pix = head[PIX_POS +: D_WIDTH];

    naneye_out_fifo #(
        .W     (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .SCLOCK  (SCLOCK),
        .RESET   (RESET),
        .wr_en   (wr_en),
        .wr_data ({FRAME_SYNC, LINE_END, PAR_EN, PAR_IN}),
        .rd_en   (pop),
        .rd_data (head),
        .count   (count),
        .empty   (empty),
        .wr_ok   (wr_ok)
    );

    // A pixel+eol pop keeps H_SYNC high for its own tick; a flag-only eol drops it at once.
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        h_n     = H_SYNC;
        par_n   = PAR_OUT;
        hb_n    = hb_cnt;
        und_n   = UNDERRUN;
        if (tick) begin
            case (state)
                WAIT: begin
                    if (!empty && (!hd_pv || count >= CW'(PREFILL) || eol_cnt != '0)) begin
                        pop     = 1'b1;
                        par_n   = hd_pv ? hd_pix : PAR_OUT;
                        h_n     = hd_pv;
                        state_n = hd_eol ? BLANK : (hd_pv ? LINE : WAIT);
                    end
                end
                LINE: begin
                    if (empty) begin
                        und_n = 1'b1;
                    end else begin
                        pop     = 1'b1;
                        par_n   = hd_pv ? hd_pix : PAR_OUT;
                        h_n     = hd_eol ? hd_pv : H_SYNC;
                        state_n = hd_eol ? BLANK : LINE;
                    end
                end
                BLANK: begin
                    h_n     = 1'b0;
                    hb_n    = hb_cnt == HBW'(HB_MIN - 1) ? '0 : hb_cnt + 1'b1;
                    state_n = hb_cnt == HBW'(HB_MIN - 1) ? WAIT : BLANK;
                end
                default: state_n = WAIT;
            endcase
        end
        vs_n  = (pop && hd_sof) ? VSW'(VS_WIDTH) : (tick && vs_cnt != '0) ? vs_cnt - 1'b1 : vs_cnt;
        eol_n = eol_cnt + CW'(wr_ok && LINE_END) - CW'(pop && hd_eol);
    end

    always_ff @(posedge SCLOCK) begin
        if (RESET) begin
            state    <= WAIT;
            div_cnt  <= '0;
            PCLK     <= 1'b0;
            PAR_OUT  <= '0;
            H_SYNC   <= 1'b0;
            V_SYNC   <= 1'b0;
            OVERFLOW <= 1'b0;
            UNDERRUN <= 1'b0;
            eol_cnt  <= '0;
            hb_cnt   <= '0;
            vs_cnt   <= '0;
        end else begin
            state    <= state_n;
            div_cnt  <= div_n;
            PCLK     <= div_n >= DIVW'(PCLK_DIV / 2);
            PAR_OUT  <= par_n;
            H_SYNC   <= h_n;
            V_SYNC   <= vs_n != '0;
            OVERFLOW <= OVERFLOW | (wr_en & ~wr_ok);
            UNDERRUN <= und_n;
            eol_cnt  <= eol_n;
            hb_cnt   <= hb_n;
            vs_cnt   <= vs_n;
        end
    end

endmodule

// File: tb/tb_naneye_out_fmt.sv
// tb_naneye_out_fmt: directed self-checking bench for naneye_out_fmt
module tb_naneye_out_fmt;
    localparam int DW = 10;
    localparam int PD = 4;

    logic          SCLOCK = 1'b0;
    logic          RESET = 1'b1;
    logic [DW-1:0] PAR_IN = '0;
    logic          PAR_EN = 1'b0, LINE_END = 1'b0, FRAME_SYNC = 1'b0;
    logic [DW-1:0] PAR_OUT;
    logic          H_SYNC, V_SYNC, PCLK, OVERFLOW, UNDERRUN;

    int          errors = 0;
    int          checks = 0;
    int          max_cnt = 0;
    logic        pclk_q = 1'b0;
    logic [11:0] lg [$];

    naneye_out_fmt #(
        .D_WIDTH    (DW),
        .PCLK_DIV   (PD),
        .FIFO_DEPTH (8),
        .PREFILL    (4),
        .HB_MIN     (2),
        .VS_WIDTH   (3)
    ) dut (
        .SCLOCK     (SCLOCK),
        .RESET      (RESET),
        .PAR_IN     (PAR_IN),
        .PAR_EN     (PAR_EN),
        .LINE_END   (LINE_END),
        .FRAME_SYNC (FRAME_SYNC),
        .PAR_OUT    (PAR_OUT),
        .H_SYNC     (H_SYNC),
        .V_SYNC     (V_SYNC),
        .PCLK       (PCLK),
        .OVERFLOW   (OVERFLOW),
        .UNDERRUN   (UNDERRUN)
    );

    always #5 SCLOCK = ~SCLOCK;

    // one log entry {V_SYNC, H_SYNC, PAR_OUT} per tick, taken on the falling SCLOCK edge after PCLK falls
    always @(negedge SCLOCK) begin
        if (pclk_q && !PCLK) lg.push_back({V_SYNC, H_SYNC, PAR_OUT});
        pclk_q <= PCLK;
        if (int'(dut.u_fifo.count) > max_cnt) max_cnt <= int'(dut.u_fifo.count);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h required=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge SCLOCK);
        #1;
    endtask

    task automatic put(input logic [DW-1:0] p, input logic en, input logic le, input logic fs);
        PAR_IN = p; PAR_EN = en; LINE_END = le; FRAME_SYNC = fs;
        step(1);
        PAR_EN = 1'b0; LINE_END = 1'b0; FRAME_SYNC = 1'b0;
    endtask

    task automatic wait_tick;
        int   n = 0;
        logic p;
        do begin
            p = PCLK;
            step(1);
            n++;
        end while (!(p && !PCLK) && n < 2 * PD);
        chk("tick_seen", 32'({p, PCLK}), 32'b10);
    endtask

    function automatic int cnt_bit(input int from, input int b);
        int n = 0;
        for (int i = from; i < lg.size(); i++) if (lg[i][b]) n++;
        return n;
    endfunction

    function automatic int first_bit(input int from, input int b);
        for (int i = from; i < lg.size(); i++) if (lg[i][b]) return i;
        return -1;
    endfunction

    function automatic int last_bit(input int from, input int b);
        int r = -1;
        for (int i = from; i < lg.size(); i++) if (lg[i][b]) r = i;
        return r;
    endfunction

    function automatic int hpix(input int from, input int k);
        int n = 0;
        for (int i = from; i < lg.size(); i++) begin
            if (lg[i][10]) begin
                if (n == k) return int'(lg[i][9:0]);
                n++;
            end
        end
        return -1;
    endfunction

    initial begin
        int m, fh, fv, lh, bad, prev;
        // reset during traffic
        step(3);
        RESET = 1'b0;
        for (int i = 1; i <= 6; i++) put(10'('h0A0 + i), 1'b1, 1'b0, 1'b0);
        step(12);
        chk("pre_reset_hsync", 32'(H_SYNC), 1);
        RESET = 1'b1;
        step(2);
        RESET = 1'b0;
        chk("rst_par_out", 32'(PAR_OUT), 0);
        chk("rst_hsync", 32'(H_SYNC), 0);
        chk("rst_vsync", 32'(V_SYNC), 0);
        chk("rst_pclk", 32'(PCLK), 0);
        chk("rst_overflow", 32'(OVERFLOW), 0);
        chk("rst_underrun", 32'(UNDERRUN), 0);
        chk("rst_fifo_count", 32'(dut.u_fifo.count), 0);
        step(1);
        chk("pclk_c1", 32'(PCLK), 0);
        step(1);
        chk("pclk_c2_rise", 32'(PCLK), 1);
        step(1);
        chk("pclk_c3", 32'(PCLK), 1);
        step(1);
        chk("pclk_c4_fall", 32'(PCLK), 0);
        m = lg.size();
        step(20);
        chk("rst_discard_no_line", cnt_bit(m, 10), 0);

        // frame sync then a three-pixel line
        m = lg.size();
        put(10'h000, 1'b0, 1'b0, 1'b1);
        put(10'h001, 1'b1, 1'b0, 1'b0);
        put(10'h002, 1'b1, 1'b0, 1'b0);
        put(10'h3FF, 1'b1, 1'b1, 1'b0);
        step(48);
        chk("l1_vsync_ticks", cnt_bit(m, 11), 3);
        chk("l1_hsync_ticks", cnt_bit(m, 10), 3);
        chk("l1_pix0", hpix(m, 0), 'h001);
        chk("l1_pix1", hpix(m, 1), 'h002);
        chk("l1_pix2", hpix(m, 2), 'h3FF);
        fv = first_bit(m, 11);
        fh = first_bit(m, 10);
        chk("l1_vs_lead", fh - fv, 1);
        lh = last_bit(m, 10);
        chk("l1_blank_after", 32'({lg[lh + 1][10], lg[lh + 2][10]}), 0);
        chk("l1_par_hold", 32'(PAR_OUT), 'h3FF);

        // prefill threshold, then underrun
        m = lg.size();
        put(10'h011, 1'b1, 1'b0, 1'b0);
        put(10'h012, 1'b1, 1'b0, 1'b0);
        put(10'h013, 1'b1, 1'b0, 1'b0);
        step(20);
        chk("pf_no_line", cnt_bit(m, 10), 0);
        chk("pf_underrun_clear", 32'(UNDERRUN), 0);
        put(10'h014, 1'b1, 1'b0, 1'b0);
        step(40);
        chk("ur_flag", 32'(UNDERRUN), 1);
        chk("ur_hsync_hold", 32'(H_SYNC), 1);
        chk("ur_par_hold", 32'(PAR_OUT), 'h014);
        chk("pf_pix0", hpix(m, 0), 'h011);
        chk("pf_pix1", hpix(m, 1), 'h012);
        chk("pf_pix2", hpix(m, 2), 'h013);
        chk("pf_pix3", hpix(m, 3), 'h014);
        put(10'h015, 1'b1, 1'b1, 1'b0);
        step(24);
        chk("ur_line_closed", 32'(H_SYNC), 0);
        chk("ur_last_pix", 32'(PAR_OUT), 'h015);
        chk("ur_sticky", 32'(UNDERRUN), 1);
        chk("ovf_clear_before", 32'(OVERFLOW), 0);

        // overflow burst
        m = lg.size();
        for (int i = 1; i <= 16; i++) put(10'('h100 + i), 1'b1, 1'(i == 16), 1'b0);
        step(80);
        chk("ovf_flag", 32'(OVERFLOW), 1);
        for (int k = 0; k < 8; k++) chk("ovf_first8", hpix(m, k), 'h101 + k);
        bad = 0;
        prev = 0;
        for (int i = m; i < lg.size(); i++) begin
            if (lg[i][10]) begin
                if (int'(lg[i][9:0]) < prev || int'(lg[i][9:0]) > 'h110) bad++;
                prev = int'(lg[i][9:0]);
            end
        end
        chk("ovf_in_order", bad, 0);
        chk("ovf_max_held", max_cnt, 8);
        put(10'h000, 1'b0, 1'b1, 1'b0);
        step(24);
        chk("ovf_line_closed", 32'(H_SYNC), 0);

        // single-cycle pixel + line end + frame sync
        m = lg.size();
        put(10'h2AA, 1'b1, 1'b1, 1'b1);
        step(40);
        chk("one_hsync_ticks", cnt_bit(m, 10), 1);
        chk("one_pix", hpix(m, 0), 'h2AA);
        chk("one_vsync_ticks", cnt_bit(m, 11), 3);
        fv = first_bit(m, 11);
        fh = first_bit(m, 10);
        chk("one_vs_align", fh, fv);
        chk("one_blank_next", 32'(lg[fh + 1][10]), 0);
        chk("one_fifo_empty", 32'(dut.u_fifo.count), 0);

        // lone line end in WAIT forces a two-tick blank before the next line
        wait_tick;
        put(10'h000, 1'b0, 1'b1, 1'b0);
        m = lg.size();
        put(10'h055, 1'b1, 1'b1, 1'b0);
        step(30);
        chk("le_blank_low", 32'({lg[m][10], lg[m + 1][10], lg[m + 2][10]}), 0);
        chk("le_line_start", 32'(lg[m + 3][10]), 1);
        chk("le_line_pix", 32'(lg[m + 3][9:0]), 'h055);
        chk("le_line_end", 32'(lg[m + 4][10]), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
